// File: rtl/mem_bank_row_writer_if.sv
// Row-write command channel from the bitstream loader to mem_bank_row_writer.
//   valid : command present (loader -> writer)
//   ready : writer can accept a command (writer -> loader)
//   addr  : target word-line index, [0:ADDR_W-1]
//   data  : bit-line values for the row, [0:NUM_BL-1], bit i drives bl[i]
//   last  : final command of the bitstream
// master = loader side, slave = writer side.
interface mem_bank_row_writer_if #(
    parameter int unsigned NUM_BL = 36,
    parameter int unsigned ADDR_W = 6
);
    logic              valid;
    logic              ready;
    logic [0:ADDR_W-1] addr;
    logic [0:NUM_BL-1] data;
    logic              last;

    modport master (output valid, output addr, output data, output last, input ready);
    modport slave  (input valid, input addr, input data, input last, output ready);
endinterface

// File: rtl/mem_bank_row_writer.sv
// Memory-bank row writer: drives the bl/wl configuration buses of the routing-tile SRAM
// groups. Each accepted row command runs a bit-line setup phase, a one-hot word-line pulse
// and a bit-line hold phase. Out-of-range addresses raise a sticky err; completion of the
// last command raises a sticky done and parks the block until reset.
// Ports:
//   prog_clk   : programming clock
//   prog_reset : synchronous active-high reset
//   cfg        : row-command channel (slave side: valid/addr/data/last in, ready out)
//   bl         : bit lines, [0:NUM_BL-1]
//   wl         : word lines, [0:NUM_WL-1], at most one high
//   done       : sticky, last command completed
//   err        : sticky, out-of-range address accepted
module mem_bank_row_writer #(
    parameter int unsigned NUM_BL    = 36,
    parameter int unsigned NUM_WL    = 36,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    mem_bank_row_writer_if.slave  cfg,
    output logic [0:NUM_BL-1]     bl,
    output logic [0:NUM_WL-1]     wl,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MaxCyc = (MaxSp > HOLD_CYC) ? MaxSp : HOLD_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StFinished
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [0:ADDR_W-1] addr_q, addr_d;
    logic [0:NUM_BL-1] data_q, data_d;
    logic              last_q, last_d;
    logic [0:NUM_BL-1] bl_q, bl_d;
    logic [0:NUM_WL-1] wl_q, wl_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              addr_ok;

    // ready_q is only high in StIdle, so it doubles as the idle qualifier.
    assign accept  = cfg.valid && ready_q;
    assign addr_ok = 32'(cfg.addr) < NUM_WL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = cfg.addr;
                    data_d = cfg.data;
                    last_d = cfg.last;
                    if (addr_ok) begin
                        state_d = StSetup;
                        cnt_d   = CntW'(SETUP_CYC);
                    end else begin
                        err_d = 1'b1;
                        if (cfg.last) begin
                            state_d = StFinished;
                        end
                    end
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StPulse;
                    cnt_d   = CntW'(PULSE_CYC);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPulse: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StHold;
                    cnt_d   = CntW'(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = last_q ? StFinished : StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFinished: begin
                state_d = StFinished;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered without
        // adding a cycle of latency relative to the state sequence.
        bl_d    = '0;
        wl_d    = '0;
        ready_d = (state_d == StIdle);
        done_d  = done_q || (state_d == StFinished);
        if (state_d == StSetup || state_d == StPulse || state_d == StHold) begin
            bl_d = data_d;
        end
        if (state_d == StPulse) begin
            wl_d[addr_d] = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            bl_q    <= '0;
            wl_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cfg.ready = ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_bank_row_writer.sv
// Bench for mem_bank_row_writer: random and directed row commands; expected word-line
// pulses are queued at acceptance and popped by a monitor when the DUT raises a word line.
// Ready/err/done/bl are checked every cycle against accept-time windows derived from the
// phase lengths. A second instance with other phase lengths gets a directed check.
module tb_mem_bank_row_writer;

    localparam int NBL = 36;
    localparam int NWL = 36;
    localparam int AW  = 6;
    localparam int S   = 1;
    localparam int P   = 2;
    localparam int H   = 1;
    localparam int INF = 1 << 30;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;
    always #5 prog_clk = ~prog_clk;

    mem_bank_row_writer_if #(.NUM_BL(NBL), .ADDR_W(AW)) cfg1 ();
    mem_bank_row_writer_if #(.NUM_BL(NBL), .ADDR_W(AW)) cfg2 ();

    logic [0:NBL-1] bl1, bl2;
    logic [0:NWL-1] wl1, wl2;
    logic           done1, err1, done2, err2;

    mem_bank_row_writer #(
        .NUM_BL(NBL), .NUM_WL(NWL), .ADDR_W(AW),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut1 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg(cfg1),
        .bl(bl1), .wl(wl1), .done(done1), .err(err1)
    );

    mem_bank_row_writer #(
        .NUM_BL(NBL), .NUM_WL(NWL), .ADDR_W(AW),
        .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
    ) dut2 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg(cfg2),
        .bl(bl2), .wl(wl2), .done(done2), .err(err2)
    );

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [0:NWL-1] onehot(input int a);
        logic [0:NWL-1] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Reference model state, written by the driver at acceptance time.
    typedef struct {
        int             start;
        int             addr;
        logic [0:NBL-1] data;
    } pulse_t;

    pulse_t         exp_q[$];
    int             busy_lo   = -10;
    int             busy_hi   = -10;
    int             err_from  = INF;
    int             done_from = INF;
    logic [0:NBL-1] bl_data   = '0;
    bit             mon_en    = 1'b0;
    bit             mon_abort = 1'b0;

    // Monitor
    initial begin
        bit             in_pulse;
        int             plen;
        logic [0:NWL-1] pulse_wl;
        logic [0:NBL-1] exp_bl;
        pulse_t         e;
        in_pulse = 1'b0;
        plen     = 0;
        pulse_wl = '0;
        forever begin
            @(negedge prog_clk);
            if (mon_abort) begin
                in_pulse = 1'b0;
            end else if (mon_en) begin
                check("ready", cfg1.ready,
                      !(cyc >= busy_lo && cyc <= busy_hi) && cyc < done_from);
                check("err", err1, cyc >= err_from);
                check("done", done1, cyc >= done_from);
                exp_bl = (cyc >= busy_lo && cyc <= busy_hi) ? bl_data : '0;
                check("bl", bl1, exp_bl);
                if (!in_pulse && wl1 != '0) begin
                    in_pulse = 1'b1;
                    plen     = 1;
                    pulse_wl = wl1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", wl1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_start", cyc, e.start);
                        check("pulse_wl", wl1, onehot(e.addr));
                        check("pulse_bl", bl1, e.data);
                    end
                end else if (in_pulse && wl1 != '0) begin
                    plen++;
                    if (wl1 != pulse_wl) check("pulse_stable", wl1, pulse_wl);
                end else if (in_pulse) begin
                    in_pulse = 1'b0;
                    check("pulse_len", plen, P);
                end
            end
        end
    end

    function automatic logic [0:NBL-1] rand_data();
        return NBL'({$urandom(), $urandom()});
    endfunction

    // Idle cycles with the command fields scrambled and valid low.
    task automatic idle(input int n);
        repeat (n) begin
            cfg1.addr = AW'($urandom());
            cfg1.data = rand_data();
            @(negedge prog_clk);
        end
    endtask

    // Entered and left at a negedge; t is the acceptance cycle (-1 on timeout).
    task automatic send(input int a, input logic [0:NBL-1] d, input bit last, output int t);
        int n;
        n = 0;
        cfg1.valid = 1'b1;
        cfg1.addr  = AW'(a);
        cfg1.data  = d;
        cfg1.last  = last;
        while (!cfg1.ready && n < 40) begin
            @(negedge prog_clk);
            n++;
        end
        if (!cfg1.ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: addr %0d never accepted (cycle %0d)", a, cyc);
            cfg1.valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        if (a < NWL) begin
            exp_q.push_back('{start: t + S + 1, addr: a, data: d});
            busy_lo = t + 1;
            busy_hi = t + S + P + H;
            bl_data = d;
            if (last) done_from = t + S + P + H + 1;
        end else begin
            if (err_from > t + 1) err_from = t + 1;
            if (last) done_from = t + 1;
        end
        @(negedge prog_clk);
        cfg1.valid = 1'b0;
        cfg1.last  = 1'b0;
    endtask

    initial begin
        int             t, t1, t2, t3, w;
        logic [0:NBL-1] d2;
        logic [0:NBL-1] three;
        three = 36'h3;
        cfg1.valid = 1'b0; cfg1.addr = '0; cfg1.data = '0; cfg1.last = 1'b0;
        cfg2.valid = 1'b0; cfg2.addr = '0; cfg2.data = '0; cfg2.last = 1'b0;

        // Reset values
        repeat (3) @(negedge prog_clk);
        prog_reset = 1'b0;
        check("rst_ready", cfg1.ready, 1);
        check("rst_bl", bl1, 0);
        check("rst_wl", wl1, 0);
        check("rst_done", done1, 0);
        check("rst_err", err1, 0);
        mon_en = 1'b1;
        idle(2);

        // Single row with command fields toggling while it is in flight
        send(5, three, 1'b0, t);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge prog_clk);
            check("row5_bl", bl1, (k <= 4) ? three : '0);
            check("row5_wl", wl1, (k == 2 || k == 3) ? onehot(5) : '0);
            cfg1.addr = AW'($urandom());
            cfg1.data = rand_data();
        end
        check("row5_ready_back", cfg1.ready, 1);

        // Out-of-range address, then a valid row accepted the very next cycle
        send(40, rand_data(), 1'b0, t1);
        send(7, rand_data(), 1'b0, t2);
        check("bad_next_accept", t2, t1 + 1);
        check("bad_err_set", err1, 1);
        idle(6);

        // Reset in the first PULSE cycle
        send(9, rand_data(), 1'b0, t);
        @(negedge prog_clk);
        #1;
        prog_reset = 1'b1;
        mon_abort  = 1'b1;
        @(negedge prog_clk);
        check("midrst_wl", wl1, 0);
        check("midrst_bl", bl1, 0);
        check("midrst_ready", cfg1.ready, 1);
        check("midrst_done", done1, 0);
        check("midrst_err", err1, 0);
        #1;
        prog_reset = 1'b0;
        exp_q.delete();
        busy_lo   = -10;
        busy_hi   = -10;
        err_from  = INF;
        done_from = INF;
        mon_abort = 1'b0;
        idle(2);

        // Randomized rows, some out of range
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 47)), rand_data(), 1'b0, t);
            idle(int'($urandom_range(0, 2)));
        end
        idle(6);

        // Back-to-back rows with valid held, last on the third
        send(0, rand_data(), 1'b0, t);
        send(17, rand_data(), 1'b0, t);
        send(35, rand_data(), 1'b1, t3);
        w = 0;
        while (!done1 && w < 20) begin
            @(negedge prog_clk);
            w++;
        end
        check("done_cycle", cyc, t3 + S + P + H + 1);
        cfg1.valid = 1'b1;
        cfg1.addr  = AW'(3);
        cfg1.data  = rand_data();
        repeat (8) @(negedge prog_clk);
        cfg1.valid = 1'b0;
        check("finished_ready", cfg1.ready, 0);

        // Second instance: SETUP=3, PULSE=1, HOLD=2
        d2 = rand_data();
        check("p2_ready_idle", cfg2.ready, 1);
        cfg2.valid = 1'b1;
        cfg2.addr  = '0;
        cfg2.data  = d2;
        @(negedge prog_clk);
        cfg2.valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check("p2_wl", wl2, (k == 4) ? onehot(0) : '0);
            check("p2_bl", bl2, (k <= 6) ? d2 : '0);
            check("p2_ready", cfg2.ready, k >= 7);
            if (k < 8) @(negedge prog_clk);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
